// File: rtl/eu_operand_responder_pkg.sv
// Shared types for the EU operand responder: exec-unit address/data and result-buffer entry.
package eu_operand_responder_pkg;

    localparam int unsigned EU_IDX_W     = 4;
    localparam int unsigned UID_W        = 8;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned EU_RSP_LANES = 2;

    typedef logic [UID_W-1:0]  type_uid;
    typedef logic [DATA_W-1:0] type_exec_unit_data;

    typedef struct packed {
        logic [EU_IDX_W-1:0] eu_idx;
        type_uid             uid;
        logic                spec;
    } type_exec_unit_addr;

    typedef struct packed {
        logic               valid;
        logic               spec;
        type_uid            uid;
        type_exec_unit_data data;
    } type_eu_rsp_entry;

endpackage

// File: rtl/eu_rsp_free_finder.sv
// Lowest-index free slot finder with a full flag over the buffer valid bits.
module eu_rsp_free_finder #(
    parameter int unsigned NUM_ENTRIES = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] valid,
    output logic [IDX_W-1:0]       free_idx_c,
    output logic                   full_c
);

    // Scan from the top down so the lowest free index is the one left standing.
    always_comb begin
        free_idx_c = '0;
        full_c     = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx_c = IDX_W'(i);
                full_c     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/eu_operand_responder.sv
// Producer-side result buffer answering two operand lookup lanes by uid.
// Optional same-cycle write-to-lookup forwarding is enabled by defining EU_RSP_BYPASS_EN.
module eu_operand_responder
    import eu_operand_responder_pkg::*;
#(
    parameter int unsigned EU_IDX      = 0,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  type_uid            wr_uid_i,
    input  logic               wr_spec_i,
    input  type_exec_unit_data wr_data_i,
    input  logic               req0_valid_i,
    input  type_exec_unit_addr req0_addr_i,
    input  logic               req0_consume_i,
    input  logic               req1_valid_i,
    input  type_exec_unit_addr req1_addr_i,
    input  logic               req1_consume_i,
    output type_exec_unit_data rsp0_data_o,
    output logic               rsp0_success_o,
    output type_exec_unit_data rsp1_data_o,
    output logic               rsp1_success_o,
    input  logic               flush_spec_i,
    input  logic               commit_spec_i,
    output logic [CNT_W-1:0]   occupancy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    type_eu_rsp_entry   entries_q [NUM_ENTRIES];
    type_eu_rsp_entry   entries_d [NUM_ENTRIES];
    type_exec_unit_data rsp_data_q [EU_RSP_LANES];
    type_exec_unit_data rsp_data_d [EU_RSP_LANES];
    logic               rsp_success_q [EU_RSP_LANES];
    logic               rsp_success_d [EU_RSP_LANES];
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               ready_q, ready_d;

    logic               req_valid   [EU_RSP_LANES];
    type_exec_unit_addr req_addr    [EU_RSP_LANES];
    logic               req_consume [EU_RSP_LANES];
    logic               hit         [EU_RSP_LANES];
    logic [IDX_W-1:0]   hit_idx     [EU_RSP_LANES];

    logic [NUM_ENTRIES-1:0] valid_vec;
    logic [IDX_W-1:0]       free_idx;
    logic                   full;
    logic                   wr_match;
    logic [IDX_W-1:0]       wr_match_idx;
    logic [IDX_W-1:0]       wr_idx;
    logic                   wr_store;
`ifdef EU_RSP_BYPASS_EN
    logic                   byp_consume;
`endif

    assign req_valid[0]   = req0_valid_i;
    assign req_valid[1]   = req1_valid_i;
    assign req_addr[0]    = req0_addr_i;
    assign req_addr[1]    = req1_addr_i;
    assign req_consume[0] = req0_consume_i;
    assign req_consume[1] = req1_consume_i;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_vec[i] = entries_q[i].valid;
        end
    end

    eu_rsp_free_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free_finder (
        .valid      (valid_vec),
        .free_idx_c (free_idx),
        .full_c     (full)
    );

    // Lookups and the write both see pre-update state; updates apply as consume, flush/commit, write.
    always_comb begin
        entries_d    = entries_q;
        wr_match     = 1'b0;
        wr_match_idx = '0;
        wr_idx       = '0;
        wr_store     = 1'b0;
        occ_d        = '0;
        ready_d      = 1'b1;
`ifdef EU_RSP_BYPASS_EN
        byp_consume  = 1'b0;
`endif
        for (int l = 0; l < EU_RSP_LANES; l++) begin
            hit[l]           = 1'b0;
            hit_idx[l]       = '0;
            rsp_success_d[l] = 1'b0;
            rsp_data_d[l]    = '0;
            if (req_valid[l] && req_addr[l].eu_idx == EU_IDX_W'(EU_IDX)) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (entries_q[i].valid && entries_q[i].uid == req_addr[l].uid &&
                        entries_q[i].spec == req_addr[l].spec) begin
                        hit[l]     = 1'b1;
                        hit_idx[l] = IDX_W'(i);
                    end
                end
            end
            if (hit[l]) begin
                rsp_success_d[l] = 1'b1;
                rsp_data_d[l]    = entries_q[hit_idx[l]].data;
            end
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries_q[i].valid && entries_q[i].uid == wr_uid_i) begin
                wr_match     = 1'b1;
                wr_match_idx = IDX_W'(i);
            end
        end
        wr_store = wr_valid_i && (wr_match || !full) && !(flush_spec_i && wr_spec_i);
        wr_idx   = wr_match ? wr_match_idx : free_idx;

`ifdef EU_RSP_BYPASS_EN
        for (int l = 0; l < EU_RSP_LANES; l++) begin
            if (wr_store && req_valid[l] && req_addr[l].eu_idx == EU_IDX_W'(EU_IDX) &&
                req_addr[l].uid == wr_uid_i && req_addr[l].spec == wr_spec_i) begin
                rsp_success_d[l] = 1'b1;
                rsp_data_d[l]    = wr_data_i;
                if (req_consume[l]) begin
                    byp_consume = 1'b1;
                end
            end
        end
        if (byp_consume) begin
            wr_store = 1'b0;
        end
`endif

        for (int l = 0; l < EU_RSP_LANES; l++) begin
            if (hit[l] && req_consume[l]) begin
                entries_d[hit_idx[l]].valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (flush_spec_i) begin
                if (entries_d[i].spec) begin
                    entries_d[i].valid = 1'b0;
                end
            end else if (commit_spec_i) begin
                entries_d[i].spec = 1'b0;
            end
        end
        if (wr_store) begin
            entries_d[wr_idx].valid = 1'b1;
            entries_d[wr_idx].spec  = wr_spec_i && !commit_spec_i;
            entries_d[wr_idx].uid   = wr_uid_i;
            entries_d[wr_idx].data  = wr_data_i;
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_d = occ_d + CNT_W'(entries_d[i].valid);
        end
        ready_d = (occ_d < CNT_W'(NUM_ENTRIES));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            for (int l = 0; l < EU_RSP_LANES; l++) begin
                rsp_data_q[l]    <= '0;
                rsp_success_q[l] <= 1'b0;
            end
            occ_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            entries_q     <= entries_d;
            rsp_data_q    <= rsp_data_d;
            rsp_success_q <= rsp_success_d;
            occ_q         <= occ_d;
            ready_q       <= ready_d;
        end
    end

    assign rsp0_data_o    = rsp_data_q[0];
    assign rsp0_success_o = rsp_success_q[0];
    assign rsp1_data_o    = rsp_data_q[1];
    assign rsp1_success_o = rsp_success_q[1];
    assign occupancy_o    = occ_q;
    assign wr_ready_o     = ready_q;

endmodule

// File: doc/eu_operand_responder.md
Name: eu_operand_responder

Overview:
Producer-side result buffer for one execution unit (EU). It holds recently produced ALU results tagged by uid and answers operand lookups from two requester ports (op0/op1 lanes) with data plus success. Its rsp*_data_o/rsp*_success_o drive the fopX/opX data/success inputs of the operand prepop stage in consumer EUs. Entries are freed on explicit consume, or dropped on speculation flush.

Parameters:
EU_IDX, 0, index of the owning EU; requests addressed to other EUs always miss
NUM_ENTRIES, 8, result buffer depth (power of 2, >=2)
CNT_W, $clog2(NUM_ENTRIES+1), occupancy counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_valid_i  in  1  ALU result write request
wr_ready_o  out  1  buffer can accept a write this cycle
wr_uid_i  in  type_exec_unit_addr.uid  uid of result
wr_spec_i  in  1  result is speculative
wr_data_i  in  type_exec_unit_data  result value
req0_valid_i  in  1  lane-0 lookup valid
req0_addr_i  in  type_exec_unit_addr  lane-0 requested address (eu_idx, uid, spec)
req0_consume_i  in  1  free entry on hit
req1_valid_i / req1_addr_i / req1_consume_i  same as lane 0
rsp0_data_o  out  type_exec_unit_data  lane-0 returned data
rsp0_success_o  out  1  lane-0 hit
rsp1_data_o / rsp1_success_o  same as lane 0
flush_spec_i  in  1  invalidate all speculative entries
commit_spec_i  in  1  clear spec flag on all entries
occupancy_o  out  CNT_W  number of valid entries

Behaviour:
- Reset (async, reset_n=0): all entry valid bits cleared; rsp*_data_o=0, rsp*_success_o=0, occupancy_o=0, wr_ready_o=1 once released.
- Lookup hit: req valid & addr.eu_idx==EU_IDX & entry valid & uid match & spec match. At most one entry per uid, enforced by write rule.
- Latency: responses registered, 1 cycle after request. Hit -> success=1, data=entry data. Miss or no request -> success=0, data=0.
- Consume: hit with consume_i=1 clears that entry's valid at the same edge the response registers. Both lanes consume same entry -> freed once; both lanes still get success=1.
- Write: accepted when wr_valid_i & wr_ready_o. If a valid entry has the same uid, overwrite data/spec in place; else allocate the lowest-index free entry. Write needs no ready when overwriting.
- wr_ready_o = (occupancy_o < NUM_ENTRIES) from registered state only. Same-cycle consume does not make room.
- Write and request to the same uid in the same cycle: request sees pre-write state (miss), unless EU_RSP_BYPASS_EN.
- flush_spec_i: at the edge, clears valid on every entry with spec=1. An incoming write with wr_spec_i=1 that cycle is dropped; a non-spec write proceeds. Lookups that cycle still use pre-flush state.
- commit_spec_i: clears spec on all valid entries and on the same-cycle incoming write. flush_spec_i wins if both are asserted.
- occupancy_o: registered popcount of valid bits after all updates.
- Reset asserted mid-operation: state is lost immediately; no response is produced for in-flight requests.

Optional Feature:
EU_RSP_BYPASS_EN
- Defined: a lookup matching the same-cycle accepted write (uid, spec, eu_idx) returns wr_data_i with success=1 next cycle. If consume_i=1 on that lookup, the write is not stored.
- Undefined: no forwarding; the same-cycle lookup misses and the write is stored.

Decomposition:
- pkg_dtypes: add type_eu_rsp_entry (valid, spec, uid, data) and the lane-count constant EU_RSP_LANES=2. type_exec_unit_addr and type_exec_unit_data are reused.
- Sub-module eu_rsp_free_finder: combinational lowest-free-index priority encoder plus full flag, over NUM_ENTRIES valid bits.

Test Plan:
- Write uid=3, data=0xA5, spec=0; next cycle req0 (EU_IDX, uid 3, spec 0, consume=0) -> rsp0 success=1, data=0xA5 next cycle, occupancy_o=1.
- req0 and req1 both hit uid 3 with consume=1 -> both success=1, data=0xA5; occupancy_o=0; a following lookup of uid 3 misses.
- Fill 8 entries -> wr_ready_o=0; 9th write with new uid is ignored. Consume one -> wr_ready_o=1 the cycle after.
- Entries uid 1 (spec=1) and uid 2 (spec=0); flush_spec_i=1 -> occupancy_o=1, uid 1 misses, uid 2 hits. Repeat with commit and flush both asserted -> flush wins.
- Request with eu_idx != EU_IDX and matching uid -> success=0, data=0.
- Same-cycle write uid 5 and req0 uid 5 -> success=0 without EU_RSP_BYPASS_EN; success=1, data=wr_data_i with it.
